avalon_bram_arbiter: RTL

- Two-host Avalon-MM arbiter that shares one burst-capable 32-bit Avalon agent (the on-chip block-RAM agent) between host 0 and host 1.
- Typical pairing: host 0 is the video/streaming reader, host 1 is the CPU/writer.
- Round-robin grant, held for a whole burst. One transaction outstanding at a time, so read-data routing is unambiguous.

---
 rtl/avalon_arb_pkg.sv | 22 ++
 rtl/rr_pick2.sv | 23 ++
 rtl/avalon_bram_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_arb_pkg.sv
// -----------------------------------------------------------------------------
// avalon_arb_pkg
// Shared types and constants for the two-host Avalon-MM block-RAM arbiter.
//   arb_state_t : arbiter FSM encoding (also exported on the debug port)
//   NB_HOSTS    : number of hosts sharing the agent
//   DATA_W      : Avalon data width
//   BE_W        : byteenable width derived from DATA_W
// -----------------------------------------------------------------------------
package avalon_arb_pkg;

  localparam int NB_HOSTS = 2;
  localparam int DATA_W   = 32;
  localparam int BE_W     = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_CMD   = 2'd2,
    RD_DATA  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin chooser.
//   i_req[1:0]    : request per host
//   i_last_grant  : host served most recently
//   o_valid       : at least one host requests
//   o_winner      : chosen host index (meaningful only when o_valid)
// A lone requester always wins; on a tie the host that was not served last
// wins, so neither host can starve the other.
// -----------------------------------------------------------------------------
module rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_valid,
  output logic       o_winner
);

  always_comb begin
    o_valid  = |i_req;
    o_winner = (i_req == 2'b11) ? ~i_last_grant : i_req[1];
  end

endmodule

// File: rtl/avalon_bram_arbiter.sv
// -----------------------------------------------------------------------------
// avalon_bram_arbiter
// Shares one burst-capable 32-bit Avalon-MM agent (on-chip block RAM) between
// two hosts. Round-robin grant, held for a whole burst, one transaction
// outstanding at a time so read data routing needs no tags.
//
// Ports
//   clk, reset_n            : clock, asynchronous active-low reset
//   hN_*  (N = 0, 1)        : Avalon-MM host-side agent ports
//   a_*                     : Avalon-MM host port towards the block-RAM agent
//   o_dbg_state             : current arbiter FSM state
//   o_dbg_grant             : currently granted host
//   o_dbg_err               : sticky flag, readdatavalid seen outside RD_DATA
//
// Handshake: a command/write beat transfers on a clock edge where the host
// holds read or write high and the arbiter's waitrequest to it is low; the
// arbiter only drops a host's waitrequest while that host owns the agent and
// the agent's own waitrequest is low, so a beat accepted by the host side is
// always accepted by the agent in the same cycle. Read data has no
// backpressure: every readdatavalid cycle is one beat.
// -----------------------------------------------------------------------------
module avalon_bram_arbiter
  import avalon_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int BURSTCOUNT_W = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,

  input  logic [ADDR_W-1:0]       h0_address,
  input  logic [BURSTCOUNT_W-1:0] h0_burstcount,
  input  logic                    h0_read,
  input  logic                    h0_write,
  input  logic [DATA_W-1:0]       h0_writedata,
  input  logic [BE_W-1:0]         h0_byteenable,
  output logic                    h0_waitrequest,
  output logic [DATA_W-1:0]       h0_readdata,
  output logic                    h0_readdatavalid,

  input  logic [ADDR_W-1:0]       h1_address,
  input  logic [BURSTCOUNT_W-1:0] h1_burstcount,
  input  logic                    h1_read,
  input  logic                    h1_write,
  input  logic [DATA_W-1:0]       h1_writedata,
  input  logic [BE_W-1:0]         h1_byteenable,
  output logic                    h1_waitrequest,
  output logic [DATA_W-1:0]       h1_readdata,
  output logic                    h1_readdatavalid,

  output logic [ADDR_W-1:0]       a_address,
  output logic [BURSTCOUNT_W-1:0] a_burstcount,
  output logic                    a_read,
  output logic                    a_write,
  output logic [DATA_W-1:0]       a_writedata,
  output logic [BE_W-1:0]         a_byteenable,
  input  logic                    a_waitrequest,
  input  logic [DATA_W-1:0]       a_readdata,
  input  logic                    a_readdatavalid,

  output arb_state_t              o_dbg_state,
  output logic                    o_dbg_grant,
  output logic                    o_dbg_err
);

  localparam logic [BURSTCOUNT_W-1:0] BC_ZERO = '0;
  localparam logic [BURSTCOUNT_W-1:0] BC_ONE  = BURSTCOUNT_W'(1);

  arb_state_t              r_state;
  logic                    r_grant;
  logic                    r_last_grant;
  logic [BURSTCOUNT_W-1:0] r_cnt;
  logic [BURSTCOUNT_W-1:0] r_len;
  logic                    r_err;

  logic [1:0]              w_req;
  logic                    w_pick_valid;
  logic                    w_winner;
  logic                    w_win_write;
  logic [BURSTCOUNT_W-1:0] w_win_bc;

  logic [ADDR_W-1:0]       w_g_address;
  logic                    w_g_read;
  logic                    w_g_write;
  logic [DATA_W-1:0]       w_g_writedata;
  logic [BE_W-1:0]         w_g_byteenable;

  logic                    w_wr_accept;
  logic                    w_rd_accept;
  logic                    w_last_beat;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  assign w_req = {h1_read | h1_write, h0_read | h0_write};

  rr_pick2 u_pick (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .o_valid      (w_pick_valid),
    .o_winner     (w_winner)
  );

  // Write takes priority when a host raises read and write together.
  assign w_win_write = w_winner ? h1_write      : h0_write;
  assign w_win_bc    = w_winner ? h1_burstcount : h0_burstcount;

  // Fields of the host that currently owns the agent.
  assign w_g_address    = r_grant ? h1_address    : h0_address;
  assign w_g_read       = r_grant ? h1_read       : h0_read;
  assign w_g_write      = r_grant ? h1_write      : h0_write;
  assign w_g_writedata  = r_grant ? h1_writedata  : h0_writedata;
  assign w_g_byteenable = r_grant ? h1_byteenable : h0_byteenable;

  assign w_wr_accept = (r_state == WR_BURST) & w_g_write & ~a_waitrequest;
  assign w_rd_accept = (r_state == RD_CMD)   & w_g_read  & ~a_waitrequest;
  assign w_last_beat = (r_cnt == (r_len - BC_ONE));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_len        <= BC_ONE;
      r_err        <= 1'b0;
    end else begin
      // Read data with no read in flight cannot be routed; drop it and flag.
      if (a_readdatavalid && (r_state != RD_DATA)) begin
        r_err <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_grant <= w_winner;
            r_state <= w_win_write ? WR_BURST : RD_CMD;
            r_len   <= (w_win_bc == BC_ZERO) ? BC_ONE : w_win_bc;
            r_cnt   <= '0;
          end
        end

        WR_BURST: begin
          if (w_wr_accept) begin
            if (w_last_beat) begin
              r_last_grant <= r_grant;
              r_cnt        <= '0;
              r_state      <= IDLE;
            end else begin
              r_cnt <= r_cnt + BC_ONE;
            end
          end
        end

        RD_CMD: begin
          if (w_rd_accept) begin
            r_cnt   <= '0;
            r_state <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (a_readdatavalid) begin
            if (w_last_beat) begin
              r_last_grant <= r_grant;
              r_cnt        <= '0;
              r_state      <= IDLE;
            end else begin
              r_cnt <= r_cnt + BC_ONE;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Agent-side and host-side outputs, decoded from the registered state.
  // The agent sees the latched burst length rather than the raw host field so
  // a burstcount of 0 reaches it as a legal single-beat burst.
  // ---------------------------------------------------------------------------
  always_comb begin
    a_address        = '0;
    a_burstcount     = '0;
    a_read           = 1'b0;
    a_write          = 1'b0;
    a_writedata      = '0;
    a_byteenable     = '0;
    h0_waitrequest   = 1'b1;
    h1_waitrequest   = 1'b1;
    h0_readdata      = '0;
    h1_readdata      = '0;
    h0_readdatavalid = 1'b0;
    h1_readdatavalid = 1'b0;

    case (r_state)
      WR_BURST: begin
        a_address    = w_g_address;
        a_burstcount = r_len;
        a_write      = w_g_write;
        a_writedata  = w_g_writedata;
        a_byteenable = w_g_byteenable;
        if (r_grant) h1_waitrequest = a_waitrequest;
        else         h0_waitrequest = a_waitrequest;
      end

      RD_CMD: begin
        a_address    = w_g_address;
        a_burstcount = r_len;
        a_read       = w_g_read;
        a_byteenable = w_g_byteenable;
        if (r_grant) h1_waitrequest = a_waitrequest;
        else         h0_waitrequest = a_waitrequest;
      end

      RD_DATA: begin
        if (r_grant) begin
          h1_readdatavalid = a_readdatavalid;
          h1_readdata      = a_readdata;
        end else begin
          h0_readdatavalid = a_readdatavalid;
          h0_readdata      = a_readdata;
        end
      end

      default: ;
    endcase
  end

  assign o_dbg_state = r_state;
  assign o_dbg_grant = r_grant;
  assign o_dbg_err   = r_err;

endmodule
